// File: rtl/smvm_row_collector.sv
// smvm_row_collector: tags SMVM row results, buffers them in a FIFO and drains them over ready/valid
module smvm_row_collector #(
  parameter int DATA_W = 12,
  parameter int ROW_W  = 8,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  row_count_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_last,
  output logic              done,
  output logic              overflow,
  output logic              unexpected,
  output logic [PTR_W:0]    level
);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t state_q;
  logic [ROW_W+DATA_W-1:0] mem_q [DEPTH];
  logic [ROW_W+DATA_W-1:0] head;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0] level_q, level_d;
  logic [ROW_W-1:0] tag_q, acc_q, rc_q;
  logic done_q, ovf_q, unx_q;
  logic col_in, full, pop, push, go;
  assign col_in = in_valid && state_q == COLLECT;
  assign full = level_q == (PTR_W+1)'(DEPTH);
  assign pop = out_valid && out_ready;
  // pop-then-push: a full FIFO still accepts a write when the head leaves this cycle
  assign push = col_in && !(full && !pop);
  assign go = state_q == IDLE && start && row_count_in != '0;
  assign level_d = level_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  assign head = mem_q[rptr_q];
  assign out_valid = level_q != '0;
  assign out_data = head[DATA_W-1:0];
  assign out_row = head[ROW_W+DATA_W-1:DATA_W];
  assign out_last = out_valid && out_row == rc_q - ROW_W'(1);
  assign done = done_q;
  assign overflow = ovf_q;
  assign unexpected = unx_q;
  assign level = level_q;
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= {tag_q, data_in};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      tag_q   <= '0;
      acc_q   <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unx_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
      done_q <= (state_q == IDLE && start && row_count_in == '0) || (state_q == DRAIN && level_q == '0);
      ovf_q <= !go && (ovf_q || (col_in && full && !pop));
      unx_q <= !go && (unx_q || (in_valid && state_q != COLLECT));
      case (state_q)
        IDLE: if (go) begin
          rc_q    <= row_count_in;
          tag_q   <= '0;
          acc_q   <= '0;
          state_q <= COLLECT;
        end
        COLLECT: if (in_valid) begin
          tag_q <= tag_q + ROW_W'(1);
          acc_q <= acc_q + ROW_W'(1);
          if (acc_q + ROW_W'(1) == rc_q) state_q <= DRAIN;
        end
        DRAIN: if (level_q == '0) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
